// File: rtl/pingpong_merge.sv
// rtl/pingpong_merge.sv - ping-pong lane collector: two FWFT lane FIFOs re-serialised in strict alternation
// Optional sequence-tag checking is compiled in with PINGPONG_SEQ_CHECK_EN.
module pingpong_merge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             l0_valid_i,
  output logic             l0_ready_o,
  input  logic [WIDTH-1:0] l0_operand_1_i,
  input  logic [WIDTH-1:0] l0_operand_2_i,
  input  logic             l1_valid_i,
  output logic             l1_ready_o,
  input  logic [WIDTH-1:0] l1_operand_1_i,
  input  logic [WIDTH-1:0] l1_operand_2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_operand_1_o,
  output logic [WIDTH-1:0] out_operand_2_o,
`ifdef PINGPONG_SEQ_CHECK_EN
  input  logic [TAG_W-1:0] l0_tag_i,
  input  logic [TAG_W-1:0] l1_tag_i,
  output logic             seq_err_o,
`endif
  output logic             turn_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef PINGPONG_SEQ_CHECK_EN
  localparam int ENT_W = 2 * WIDTH + TAG_W;
`else
  localparam int ENT_W = 2 * WIDTH;
`endif

  // Pointer wrap relies on natural binary overflow, hence the power-of-two restriction.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W < 1 || WIDTH < 1) begin : g_bad_param
    $error("pingpong_merge: DEPTH must be a power of 2 >= 2, WIDTH and TAG_W >= 1");
  end

  logic [ENT_W-1:0] lane_ent [2];
  logic [1:0]       lane_valid;
  logic             turn_q, turn_d;
  logic             xfer;
  logic [ENT_W-1:0] head_sel;
  logic             sel_empty;

  always_comb begin
    lane_valid = {l1_valid_i, l0_valid_i};
`ifdef PINGPONG_SEQ_CHECK_EN
    lane_ent[0] = {l0_tag_i, l0_operand_1_i, l0_operand_2_i};
    lane_ent[1] = {l1_tag_i, l1_operand_1_i, l1_operand_2_i};
`else
    lane_ent[0] = {l0_operand_1_i, l0_operand_2_i};
    lane_ent[1] = {l1_operand_1_i, l1_operand_2_i};
`endif
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty, ready, push, pop;
    logic [ENT_W-1:0] head;

    // No push-through: a full lane refuses input even while it is being popped.
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign ready = !rst_i && !full;
    assign push  = lane_valid[g] && ready;
    assign pop   = xfer && (turn_q == 1'(g));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= lane_ent[g];
    end
  end

  assign head_sel  = turn_q ? g_lane[1].head  : g_lane[0].head;
  assign sel_empty = turn_q ? g_lane[1].empty : g_lane[0].empty;

  // Strict alternation: only the turn lane may be emitted, even if the other lane has data.
  assign out_valid_o     = !rst_i && !sel_empty;
  assign out_operand_1_o = out_valid_o ? head_sel[2*WIDTH-1:WIDTH] : '0;
  assign out_operand_2_o = out_valid_o ? head_sel[WIDTH-1:0]       : '0;
  assign xfer            = out_valid_o && out_ready_i;
  assign turn_d          = turn_q ^ xfer;
  assign turn_o          = turn_q;
  assign l0_ready_o      = g_lane[0].ready;
  assign l1_ready_o      = g_lane[1].ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      turn_q <= 1'b0;
    end else begin
      turn_q <= turn_d;
    end
  end

`ifdef PINGPONG_SEQ_CHECK_EN
  logic [TAG_W-1:0] exp_tag_q, exp_tag_d;
  logic             seq_err_q, seq_err_d;

  always_comb begin
    exp_tag_d = exp_tag_q;
    seq_err_d = seq_err_q;
    if (xfer) begin
      exp_tag_d = exp_tag_q + 1'b1;
      if (head_sel[ENT_W-1 -: TAG_W] != exp_tag_q) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_tag_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_tag_q <= exp_tag_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err_o = seq_err_q;
`endif

endmodule
